// File: rtl/mem_init_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_init_loader_if
// Description : Record stream carrying byte/word writes into the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_init_loader_if #(
    parameter int BPW = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_addr;
    logic             in_byte_mode;
    logic [8*BPW-1:0] in_data;
    logic [BPW-1:0]   in_be;

    modport master (
        output in_valid,
        output in_addr,
        output in_byte_mode,
        output in_data,
        output in_be,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_byte_mode,
        input  in_data,
        input  in_be,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_init_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_init_loader
// Description : Loads a banked SRAM array from a record stream or a pattern fill.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_init_loader #(
    parameter int NUM_ROWS = 8,
    parameter int NUM_COLS = 8,
    parameter int BPW      = 4,
    parameter int LINES    = 128
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    mem_init_loader_if.slave                   stream,
    input  wire logic                          fill_start,
    input  wire logic [31:0]                   fill_base,
    input  wire logic [15:0]                   fill_len,
    input  wire logic [8*BPW-1:0]              fill_data,
    output logic [NUM_ROWS*NUM_COLS*BPW-1:0]   mem_we,
    output logic [$clog2(LINES)-1:0]           mem_line,
    output logic [8*BPW-1:0]                   mem_wdata,
    output logic                               done,
    output logic                               err_oor,
    output logic [15:0]                        wr_count
);
    localparam int c_LANE_W  = $clog2(BPW);
    localparam int c_COL_W   = $clog2(NUM_COLS);
    localparam int c_LINE_W  = $clog2(LINES);
    localparam int c_ROW_W   = $clog2(NUM_ROWS);
    localparam int ADDR_W    = c_LANE_W + c_COL_W + c_LINE_W + c_ROW_W;
    localparam int c_WORD_W  = ADDR_W - c_LANE_W;
    localparam int c_NB      = NUM_ROWS * NUM_COLS * BPW;
    localparam int c_SHIFT_W = $clog2(c_NB);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Fill pointer is a word address with one extra bit that flags "past the end".
    logic [c_WORD_W:0]     r_fill_word;
    logic [15:0]           r_fill_left;
    logic [8*BPW-1:0]      r_fill_data;

    logic [c_NB-1:0]       r_mem_we;
    logic [c_LINE_W-1:0]   r_mem_line;
    logic [8*BPW-1:0]      r_mem_wdata;
    logic                  r_done;
    logic                  r_err_oor;
    logic [15:0]           r_wr_count;

    logic                  w_accept;
    logic                  w_in_oor;
    logic                  w_wr_en;
    logic [c_WORD_W-1:0]   w_wr_word;
    logic [BPW-1:0]        w_wr_mask;
    logic [8*BPW-1:0]      w_wr_data;
    logic                  w_done;
    logic                  w_oor;
    logic                  w_fill_load;
    logic                  w_fill_step;
    logic [c_SHIFT_W-1:0]  w_shift;
    logic [c_NB-1:0]       w_we_next;
    logic                  w_unused;

    assign stream.in_ready = (r_state == IDLE) && !fill_start && !rst;
    assign w_accept        = stream.in_valid && stream.in_ready;
    assign w_in_oor        = |stream.in_addr[31:ADDR_W];
    assign w_unused        = &{1'b0, fill_base[c_LANE_W-1:0]};

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_wr_word    = '0;
        w_wr_mask    = '0;
        w_wr_data    = '0;
        w_done       = 1'b0;
        w_oor        = 1'b0;
        w_fill_load  = 1'b0;
        w_fill_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (fill_start) begin
                    if (fill_len == 16'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_fill_load  = 1'b1;
                        w_state_next = FILL;
                    end
                end else if (w_accept) begin
                    if (w_in_oor) begin
                        w_oor = 1'b1;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_word = stream.in_addr[ADDR_W-1:c_LANE_W];
                        if (stream.in_byte_mode) begin
                            w_wr_mask = {{(BPW-1){1'b0}}, 1'b1} << stream.in_addr[c_LANE_W-1:0];
                            w_wr_data = {BPW{stream.in_data[7:0]}};
                        end else begin
                            w_wr_mask = stream.in_be;
                            w_wr_data = stream.in_data;
                        end
                    end
                end
            end
            FILL: begin
                // Length is exhausted before the range check, so a fill ending exactly at the top is clean.
                if (r_fill_left == 16'd0) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_fill_word[c_WORD_W]) begin
                    w_oor        = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_wr_en     = 1'b1;
                    w_wr_word   = r_fill_word[c_WORD_W-1:0];
                    w_wr_mask   = '1;
                    w_wr_data   = r_fill_data;
                    w_fill_step = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bank index {row, col} scaled by the lane count locates the strobe group.
    always_comb begin
        w_shift   = {w_wr_word[c_WORD_W-1:c_COL_W+c_LINE_W], w_wr_word[c_COL_W-1:0], {c_LANE_W{1'b0}}};
        w_we_next = '0;
        if (w_wr_en) begin
            w_we_next = c_NB'(w_wr_mask) << w_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_word <= '0;
            r_fill_left <= '0;
            r_fill_data <= '0;
            r_mem_we    <= '0;
            r_mem_line  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err_oor   <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            r_mem_we <= w_we_next;
            r_done   <= w_done;
            if (w_wr_en) begin
                r_mem_line  <= w_wr_word[c_COL_W+c_LINE_W-1:c_COL_W];
                r_mem_wdata <= w_wr_data;
            end
            if (w_oor) begin
                r_err_oor <= 1'b1;
            end
            if ((|w_we_next) && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_fill_load) begin
                r_fill_word <= {|fill_base[31:ADDR_W], fill_base[ADDR_W-1:c_LANE_W]};
                r_fill_left <= fill_len;
                r_fill_data <= fill_data;
            end else if (w_fill_step) begin
                r_fill_word <= r_fill_word + 1'b1;
                r_fill_left <= r_fill_left - 16'd1;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_line  = r_mem_line;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign err_oor   = r_err_oor;
    assign wr_count  = r_wr_count;
endmodule
`default_nettype wire

// File: tb/tb_mem_init_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_init_loader
// Description : Scoreboard bench for mem_init_loader with random records and fills.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_init_loader;
    localparam int     NR    = 8;
    localparam int     NC    = 8;
    localparam int     BPW   = 4;
    localparam int     LINES = 128;
    localparam int     NB    = NR * NC * BPW;
    localparam longint TOP   = 64'd32768;

    typedef struct {
        logic [NB-1:0] we;
        logic [6:0]    line;
        logic [31:0]   data;
        logic [15:0]   cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fill_start = 1'b0;
    logic [31:0]   fill_base = '0;
    logic [15:0]   fill_len = '0;
    logic [31:0]   fill_data = '0;
    logic [NB-1:0] mem_we;
    logic [6:0]    mem_line;
    logic [31:0]   mem_wdata;
    logic          done;
    logic          err_oor;
    logic [15:0]   wr_count;

    mem_init_loader_if #(.BPW(BPW)) stream ();

    mem_init_loader #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .BPW(BPW), .LINES(LINES)
    ) dut (
        .clk(clk), .rst(rst), .stream(stream),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
        .mem_we(mem_we), .mem_line(mem_line), .mem_wdata(mem_wdata),
        .done(done), .err_oor(err_oor), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_seen = 0;
    int   ref_cnt = 0;
    logic ref_oor = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference placement: bank word located purely from the address arithmetic.
    function automatic logic [NB-1:0] model_we(input longint a, input logic [BPW-1:0] mask);
        logic [NB-1:0] r;
        longint row, col, base;
        r    = '0;
        row  = (a / (BPW * NC * LINES)) % NR;
        col  = (a / BPW) % NC;
        base = (row * NC + col) * BPW;
        for (int k = 0; k < BPW; k++) if (mask[k]) r[int'(base) + k] = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] model_line(input longint a);
        return 7'((a / (BPW * NC)) % LINES);
    endfunction

    task automatic push_write(input longint a, input logic [BPW-1:0] mask, input logic [31:0] data);
        exp_t e;
        if (mask != '0) begin
            ref_cnt++;
            e.we   = model_we(a, mask);
            e.line = model_line(a);
            e.data = data;
            e.cnt  = 16'(ref_cnt);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_seen++;
            if (mem_we != '0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got we=%h line=%h, required no write", mem_we, mem_line);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_we", mem_we, e.we);
                    check("wr_line", NB'(mem_line), NB'(e.line));
                    check("wr_data", NB'(mem_wdata), NB'(e.data));
                    check("wr_count", NB'(wr_count), NB'(e.cnt));
                end
            end
        end
    end

    task automatic send_rec(input logic [31:0] a, input logic bm, input logic [31:0] data, input logic [3:0] be);
        @(posedge clk); #1;
        stream.in_valid     = 1'b1;
        stream.in_addr      = a;
        stream.in_byte_mode = bm;
        stream.in_data      = data;
        stream.in_be        = be;
        if (longint'(a) >= TOP) ref_oor = 1'b1;
        else if (bm) push_write(longint'(a), 4'(1) << (a % BPW), {4{data[7:0]}});
        else push_write(longint'(a), be, data);
        #1 check("in_ready_idle", NB'(stream.in_ready), NB'(1'b1));
        @(posedge clk); #1;
        stream.in_valid = 1'b0;
        @(negedge clk);
        check("rec_err_oor", NB'(err_oor), NB'(ref_oor));
        check("rec_wr_count", NB'(wr_count), NB'(ref_cnt));
    endtask

    task automatic run_fill(input logic [31:0] base, input logic [15:0] len, input logic [31:0] data, input bit coinc);
        longint al;
        int     nw, lat, d0;
        bit     oor, found;
        @(posedge clk); #1;
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_data  = data;
        if (coinc) begin
            stream.in_valid     = 1'b1;
            stream.in_addr      = 32'($urandom_range(0, 32767));
            stream.in_byte_mode = 1'b0;
            stream.in_be        = 4'hF;
            stream.in_data      = $urandom;
        end
        al  = longint'(base) - (longint'(base) % BPW);
        nw  = 0;
        oor = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            if (al + i * BPW >= TOP) begin
                oor = 1'b1;
                break;
            end
            push_write(al + i * BPW, 4'hF, data);
            nw++;
        end
        if (oor) ref_oor = 1'b1;
        d0 = done_seen;
        #1 if (coinc) check("in_ready_coinc", NB'(stream.in_ready), NB'(1'b0));
        @(posedge clk); #1;
        fill_start      = 1'b0;
        stream.in_valid = 1'b0;
        lat   = 1;
        found = 1'b0;
        while (!found && lat <= int'(len) + 8) begin
            @(negedge clk);
            if (done) found = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check("fill_done_seen", NB'(found), NB'(1'b1));
        check("fill_latency", NB'(lat), NB'((len == 0) ? 1 : nw + 2));
        check("fill_err_oor", NB'(err_oor), NB'(ref_oor));
        check("fill_wr_count", NB'(wr_count), NB'(ref_cnt));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fill_done_pulses", NB'(done_seen - d0), NB'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        stream.in_valid     = 1'b0;
        stream.in_addr      = '0;
        stream.in_byte_mode = 1'b0;
        stream.in_data      = '0;
        stream.in_be        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", NB'(stream.in_ready), NB'(1'b0));
        check("rst_mem_we", mem_we, '0);
        check("rst_mem_line", NB'(mem_line), '0);
        check("rst_mem_wdata", NB'(mem_wdata), '0);
        check("rst_done", NB'(done), '0);
        check("rst_err_oor", NB'(err_oor), '0);
        check("rst_wr_count", NB'(wr_count), '0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        send_rec(32'h0000_1234, 1'b0, 32'hDDCC_BBAA, 4'hF);
        check("word_we_52_55", mem_we, NB'(64'h00F0_0000_0000_0000));
        check("word_line", NB'(mem_line), NB'(7'h11));
        send_rec(32'h0000_0003, 1'b1, 32'h0000_00C3, 4'h0);
        check("byte_we_3", mem_we, NB'(8'h08));
        check("byte_wdata", NB'(mem_wdata), NB'(32'hC3C3_C3C3));
        send_rec(32'h0000_8000, 1'b0, 32'h1111_2222, 4'hF);
        check("oor_rec_flag", NB'(err_oor), NB'(1'b1));
        send_rec(32'h0000_0100, 1'b0, 32'h5555_6666, 4'h5);
        check("oor_sticky", NB'(err_oor), NB'(1'b1));

        run_fill(32'h0000_7FF8, 16'd4, 32'h0, 1'b0);
        run_fill(32'h0000_0040, 16'd5, 32'hA5A5_5A5A, 1'b1);
        run_fill(32'h0000_0200, 16'd0, 32'h1234_5678, 1'b0);
        run_fill(32'h0000_9000, 16'd3, 32'hFFFF_0000, 1'b0);

        // Reset lands while the third fill write is on the outputs.
        @(posedge clk); #1;
        fill_start = 1'b1;
        fill_base  = 32'h0000_0100;
        fill_len   = 16'd10;
        fill_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) push_write(64'h100 + i * BPW, 4'hF, 32'hCAFE_F00D);
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b1;
        ref_cnt = 0;
        ref_oor = 1'b0;
        d0      = done_seen;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_we", mem_we, '0);
        check("midrst_mem_line", NB'(mem_line), '0);
        check("midrst_mem_wdata", NB'(mem_wdata), '0);
        check("midrst_wr_count", NB'(wr_count), '0);
        check("midrst_err_oor", NB'(err_oor), '0);
        check("midrst_in_ready", NB'(stream.in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", NB'(done_seen), NB'(d0));
        check("midrst_ready_after", NB'(stream.in_ready), NB'(1'b1));

        for (int it = 0; it < 60; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                logic [31:0] a;
                a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32767));
                send_rec(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                logic [31:0] b;
                b = ($urandom_range(0, 1) == 0) ? 32'(32768 - $urandom_range(1, 40))
                                                 : 32'($urandom_range(0, 32767));
                run_fill(b, 16'($urandom_range(0, 12)), $urandom, sel == 9);
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", NB'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
